// File: rtl/skew_fifo_bank.sv
// skew_fifo_bank: per-lane delay lines that skew a DIM-wide word stream for a
// systolic array. Lane i delays by BASE_DEPTH+i (SKEW_DIR=0) or by
// BASE_DEPTH+(DIM-1-i) (SKEW_DIR=1). Each stage holds a data word and a valid bit.
// inflight counts the valid words currently held across all lanes.
//
// Optional feature macro: SKEW_FIFO_BANK_ZERO_INVALID_EN
//   defined   -> dout[i] reads 0 whenever vout[i] is 0
//   undefined -> dout[i] shows last-stage data unmasked
module skew_fifo_bank #(
  parameter int BITS       = 8,
  parameter int DIM        = 8,
  parameter int BASE_DEPTH = 8,
  parameter int SKEW_DIR   = 0,
  localparam int TOTAL     = DIM*BASE_DEPTH + DIM*(DIM-1)/2,
  localparam int CW        = $clog2(TOTAL+1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      flush,
  input  logic [DIM-1:0]            vin,
  input  logic [DIM-1:0][BITS-1:0]  din,
  output logic [DIM-1:0]            vout,
  output logic [DIM-1:0][BITS-1:0]  dout,
  output logic [CW-1:0]             inflight,
  output logic                      busy
);

  // Lane data is treated as two's complement by consumers; the bank only moves bits.

  function automatic logic [CW-1:0] popcnt(input logic [DIM-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int k = 0; k < DIM; k++) begin
      c = c + CW'(v[k]);
    end
    return c;
  endfunction

  logic [CW-1:0] inflight_q;

  for (genvar g = 0; g < DIM; g++) begin : g_lane
    localparam int DL = (SKEW_DIR == 0) ? (BASE_DEPTH + g) : (BASE_DEPTH + DIM - 1 - g);

    logic [BITS-1:0] data_q [DL];
    logic [DL-1:0]   vld_q;

    // Lane shift register; invalid words move through just like valid ones.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < DL; k++) begin
          data_q[k] <= '0;
        end
        vld_q <= '0;
      end else if (flush) begin
        for (int k = 0; k < DL; k++) begin
          data_q[k] <= '0;
        end
        vld_q <= '0;
      end else if (en) begin
        data_q[0] <= din[g];
        vld_q[0]  <= vin[g];
        for (int k = 1; k < DL; k++) begin
          data_q[k] <= data_q[k-1];
          vld_q[k]  <= vld_q[k-1];
        end
      end
    end

    assign vout[g] = vld_q[DL-1];
`ifdef SKEW_FIFO_BANK_ZERO_INVALID_EN
    assign dout[g] = vld_q[DL-1] ? data_q[DL-1] : '0;
`else
    assign dout[g] = data_q[DL-1];
`endif
  end

  // Occupancy tracking: words entering minus words leaving the last stage.
  // A word leaving always frees a stage, so the count stays within TOTAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
    end else if (flush) begin
      inflight_q <= '0;
    end else if (en) begin
      inflight_q <= inflight_q + popcnt(vin) - popcnt(vout);
    end
  end

  assign inflight = inflight_q;
  assign busy     = (inflight_q != '0);

endmodule

// File: tb/tb_skew_fifo_bank.sv
// Bench for skew_fifo_bank (BITS=8, DIM=4, BASE_DEPTH=4), both skew directions.
// A scoreboard queues every word pushed on an enabled edge with its edge index;
// the word is expected at the lane output once the edge count reaches k+D-1.
module tb_skew_fifo_bank;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            flush = 1'b0;
  logic [3:0]      vin = '0;
  logic [3:0][7:0] din = '0;

  logic [3:0]      vout0, vout1;
  logic [3:0][7:0] dout0, dout1;
  logic [4:0]      inf0, inf1;
  logic            busy0, busy1;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  skew_fifo_bank #(.BITS(8), .DIM(4), .BASE_DEPTH(4), .SKEW_DIR(0)) u_dir0 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .vin(vin), .din(din),
    .vout(vout0), .dout(dout0), .inflight(inf0), .busy(busy0)
  );

  skew_fifo_bank #(.BITS(8), .DIM(4), .BASE_DEPTH(4), .SKEW_DIR(1)) u_dir1 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .vin(vin), .din(din),
    .vout(vout1), .dout(dout1), .inflight(inf1), .busy(busy1)
  );

  typedef struct {
    int         k;
    logic       v;
    logic [7:0] d;
  } ent_t;

  ent_t       q [2][4][$];
  logic       ev [2][4];
  logic [7:0] ed [2][4];
  int         ecnt = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int depth(input int u, input int i);
    return (u == 0) ? (4 + i) : (7 - i);
  endfunction

  task automatic clear_model();
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 4; i++) begin
        q[u][i].delete();
        ev[u][i] = 1'b0;
        ed[u][i] = '0;
      end
    end
  endtask

  task automatic model_edge();
    ent_t e;
    if (flush) begin
      clear_model();
    end else if (en) begin
      ecnt++;
      for (int u = 0; u < 2; u++) begin
        for (int i = 0; i < 4; i++) begin
          e.k = ecnt;
          e.v = vin[i];
          e.d = din[i];
          q[u][i].push_back(e);
          if (q[u][i][0].k + depth(u, i) - 1 == ecnt) begin
            ev[u][i] = q[u][i][0].v;
            ed[u][i] = q[u][i][0].d;
            void'(q[u][i].pop_front());
          end else begin
            ev[u][i] = 1'b0;
            ed[u][i] = '0;
          end
        end
      end
    end
  endtask

  task automatic compare_all(input string ctx);
    int         exp_inf;
    logic       ov;
    logic [7:0] od, xd;
    int         oinf, obusy;
    for (int u = 0; u < 2; u++) begin
      exp_inf = 0;
      for (int i = 0; i < 4; i++) begin
        foreach (q[u][i][j]) if (q[u][i][j].v) exp_inf++;
        if (ev[u][i]) exp_inf++;
        ov = (u == 0) ? vout0[i] : vout1[i];
        od = (u == 0) ? dout0[i] : dout1[i];
`ifdef SKEW_FIFO_BANK_ZERO_INVALID_EN
        xd = ev[u][i] ? ed[u][i] : 8'h00;
`else
        xd = ed[u][i];
`endif
        chk($sformatf("%s vout d%0d l%0d", ctx, u, i), int'(ov), int'(ev[u][i]));
        chk($sformatf("%s dout d%0d l%0d", ctx, u, i), int'(od), int'(xd));
      end
      oinf  = (u == 0) ? int'(inf0) : int'(inf1);
      obusy = (u == 0) ? int'(busy0) : int'(busy1);
      chk($sformatf("%s inflight d%0d", ctx, u), oinf, exp_inf);
      chk($sformatf("%s busy d%0d", ctx, u), obusy, int'(exp_inf != 0));
    end
  endtask

  task automatic step(input logic en_i, input logic flush_i, input logic [3:0] vin_i,
                      input logic [31:0] din_i, input string ctx);
    en    = en_i;
    flush = flush_i;
    vin   = vin_i;
    din   = din_i;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all(ctx);
  endtask

  initial begin
    clear_model();
    #3;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // single burst on all lanes, both skew directions
    step(1'b1, 1'b0, 4'hF, {8'd13, 8'd12, 8'd11, 8'd10}, "burst");
    chk("burst peak d0", int'(inf0), 4);
    chk("burst peak d1", int'(inf1), 4);
    for (int n = 0; n < 8; n++) step(1'b1, 1'b0, 4'h0, 32'h0, "drain1");

    // stall: -5 into lane 0, two enabled edges, three stalled, two enabled
    step(1'b1, 1'b0, 4'h1, 32'h0000_00FB, "stall");
    step(1'b1, 1'b0, 4'h0, 32'h0, "stall");
    for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 4'hF, $urandom(), "frozen");
    step(1'b1, 1'b0, 4'h0, 32'h0, "stall");
    step(1'b1, 1'b0, 4'h0, 32'h0, "stall");
    chk("stall exit vout", int'(vout0[0]), 1);
    chk("stall exit dout", int'(dout0[0]), 8'hFB);
    for (int n = 0; n < 8; n++) step(1'b1, 1'b0, 4'h0, 32'h0, "drain2");

    // saturation
    for (int n = 0; n < 20; n++) step(1'b1, 1'b0, 4'hF, $urandom(), "sat");
    chk("sat level d0", int'(inf0), 22);
    chk("sat level d1", int'(inf1), 22);

    // flush with ten words in flight
    step(1'b1, 1'b1, 4'hF, $urandom(), "flush0");
    step(1'b1, 1'b0, 4'hF, $urandom(), "fill");
    step(1'b1, 1'b0, 4'hF, $urandom(), "fill");
    step(1'b1, 1'b0, 4'h3, $urandom(), "fill");
    chk("pre-flush d0", int'(inf0), 10);
    step(1'b1, 1'b1, 4'hF, $urandom(), "flush1");
    chk("post-flush d0", int'(inf0), 0);
    chk("post-flush busy d1", int'(busy1), 0);

    // invalid words reach the output stage
    for (int n = 0; n < 8; n++) step(1'b1, 1'b0, 4'h0, {4{8'h7F}}, "invalid");
`ifdef SKEW_FIFO_BANK_ZERO_INVALID_EN
    chk("invalid dout", int'(dout0[0]), 0);
`else
    chk("invalid dout", int'(dout0[0]), 8'h7F);
`endif

    // random traffic, then asynchronous reset between edges
    for (int n = 0; n < 40; n++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 4'($urandom()), $urandom(), "rand");
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    compare_all("async rst");
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 4'($urandom()), $urandom(), "rand2");
    for (int n = 0; n < 8; n++) step(1'b1, 1'b0, 4'h0, 32'h0, "drain3");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/skew_fifo_bank.md
SKEW_FIFO_BANK -- requirements
Module: skew_fifo_bank

Interface
REQ-001 SHALL have parameter BITS, default 8, meaning data word width per lane (signed).
REQ-002 SHALL have parameter DIM, default 8, meaning lane count (systolic array columns).
REQ-003 SHALL have parameter BASE_DEPTH, default 8, meaning delay of the least-skewed lane, >=1.
REQ-004 SHALL have parameter SKEW_DIR, default 0, meaning 0 = lane i delay BASE_DEPTH+i, 1 = lane i delay BASE_DEPTH+(DIM-1-i).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port en  input  1  shift enable; 0 freezes all lanes.
REQ-008 SHALL have port flush  input  1  synchronous clear of all in-flight words.
REQ-009 SHALL have port vin  input  DIM  per-lane input valid.
REQ-010 SHALL have port din  input  DIM x BITS signed  per-lane input word.
REQ-011 SHALL have port vout  output  DIM  per-lane output valid (last stage valid bit).
REQ-012 SHALL have port dout  output  DIM x BITS signed  per-lane output word (last stage register).
REQ-013 SHALL have port inflight  output  $clog2(TOTAL+1)  count of valid words held, TOTAL = DIM*BASE_DEPTH + DIM*(DIM-1)/2.
REQ-014 SHALL have port busy  output  1  high when inflight != 0.

Function
REQ-015 SHALL implement per lane i a shift register of D_i stages, each stage holding BITS data plus 1 valid bit, with D_i set by SKEW_DIR per REQ-004.
REQ-016 SHALL, on a rising edge with en=1 and flush=0, shift every lane one stage, loading {vin[i], din[i]} into stage 0.
REQ-017 SHALL, with en=0 and flush=0, hold all stages, inflight and outputs unchanged.
REQ-018 SHALL present a word accepted on enabled edge k at dout[i]/vout[i] immediately after enabled edge k+D_i-1 (D_i enabled edges of latency, stalls not counted).
REQ-019 SHALL shift stage data regardless of vin; words with vin=0 propagate with valid 0.
REQ-020 SHALL, on a rising edge with flush=1, clear all data and valid bits to 0 and set inflight to 0, regardless of en, vin, din.
REQ-021 SHALL update inflight on each enabled, non-flush edge as inflight + popcount(vin) - popcount(vout), with vout sampled before the edge; simultaneous entry and exit on one lane nets zero.
REQ-022 SHALL never let inflight exceed TOTAL or underflow; no overflow condition exists because each exit frees a stage.
REQ-023 SHALL drive busy combinationally from inflight != 0.
REQ-024 SHALL support DIM=1 (single lane, delay BASE_DEPTH) and identical behaviour for both SKEW_DIR values in that case.

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear all stage data to 0, all valid bits to 0, inflight to 0; thus dout=0, vout=0, busy=0.
REQ-026 SHALL, on reset asserted mid-stream, discard all in-flight words; first post-reset word exits after full D_i latency.
REQ-027 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL honour macro SKEW_FIFO_BANK_ZERO_INVALID_EN: when defined, dout[i] is forced to 0 whenever vout[i]=0; when undefined, dout[i] shows last-stage data unmasked.
REQ-029 SHALL keep vout, inflight, busy and latency identical with or without SKEW_FIFO_BANK_ZERO_INVALID_EN.

Verification (BITS=8, DIM=4, BASE_DEPTH=4)
REQ-030 SHALL cover: SKEW_DIR=0, en=1, vin=4'hF, din={8'd13,8'd12,8'd11,8'd10} on one edge -> lane0 outputs 10 after 4 edges, lane1 11 after 5, lane2 12 after 6, lane3 13 after 7, each vout pulse one cycle.
REQ-031 SHALL cover: SKEW_DIR=1, same stimulus -> lane3 exits after 4 edges, lane0 after 7; inflight peaks at 4 then decrements to 0, busy falls with it.
REQ-032 SHALL cover: word -5 into lane 0, en low for 3 cycles after 2 enabled edges -> -5 exits after 2 further enabled edges (7 clocks total), outputs frozen during stall.
REQ-033 SHALL cover: continuous vin=4'hF for 20 edges -> inflight saturates at 22 (4+5+6+7) and holds while entry and exit balance.
REQ-034 SHALL cover: flush=1 with en=1 while inflight=10 -> next cycle inflight=0, vout=0, busy=0, stage-0 input on that edge discarded.
REQ-035 SHALL cover: rst_n pulsed low mid-stream, between clock edges -> outputs 0 immediately; with SKEW_FIFO_BANK_ZERO_INVALID_EN undefined, invalid din=8'h7F reaches dout with vout=0; defined, dout=0.
